pulse_scan_sequencer: RTL and testbench

- Steps the main-pulse delay of the pulse generator through a linear scan of points.
- Holds each point for a programmed number of averaging periods, plus settling periods that are discarded.
- Sits between the LabView-loaded register bank and the pulse generator: drives its delay input and gates its pulse output.
- Changes parameters only on period boundaries, so the pulse generator never runs a period with mixed settings.

---
 rtl/pulse_scan_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pulse_scan_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_scan_sequencer.sv
// Pulse delay scan sequencer: steps the pulse generator delay through a linear scan,
// holding each point for settling plus averaging periods, switching only on period boundaries.
module pulse_scan_sequencer #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk_pll,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             cycle_end,
    input  logic [WIDTH-1:0] delay_base,
    input  logic [WIDTH-1:0] delay_step,
    input  logic [CNT_W-1:0] n_points,
    input  logic [CNT_W-1:0] n_avg,
    output logic [WIDTH-1:0] delay_out,
    output logic             pulse_en,
    output logic             busy,
    output logic             done,
    output logic             acq_valid,
    output logic [CNT_W-1:0] point_idx,
    output logic [CNT_W-1:0] avg_idx
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [SW-1:0] SettleLoad = SW'(SETTLE_CYCLES);

    typedef enum logic [2:0] {StIdle, StArm, StSettle, StRun, StDone} state_e;

    // State entered after arming and after every delay change.
    localparam state_e StPostLoad = (SETTLE_CYCLES > 0) ? StSettle : StRun;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] delay_q, delay_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [CNT_W-1:0] pts_last_q, pts_last_d;
    logic [CNT_W-1:0] avg_last_q, avg_last_d;
    logic [CNT_W-1:0] point_q, point_d;
    logic [CNT_W-1:0] avg_q, avg_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             pulse_en_q, pulse_en_d;
    logic             done_q, done_d;
    logic             acq_q, acq_d;

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        step_d     = step_q;
        pts_last_d = pts_last_q;
        avg_last_d = avg_last_q;
        point_d    = point_q;
        avg_d      = avg_q;
        settle_d   = settle_q;
        pulse_en_d = pulse_en_q;
        done_d     = 1'b0;
        acq_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    step_d  = delay_step;
                    delay_d = delay_base;
                    point_d = '0;
                    avg_d   = '0;
                    if (n_points == '0 || n_avg == '0) begin
                        done_d = 1'b1;
                    end else begin
                        pts_last_d = n_points - CNT_W'(1);
                        avg_last_d = n_avg - CNT_W'(1);
                        state_d    = StArm;
                    end
                end
            end
            StArm: begin
                if (abort) begin
                    state_d    = StIdle;
                    pulse_en_d = 1'b0;
                end else if (cycle_end) begin
                    // Enable on the wrap so the first gated period is complete.
                    pulse_en_d = 1'b1;
                    settle_d   = SettleLoad;
                    state_d    = StPostLoad;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d    = StIdle;
                    pulse_en_d = 1'b0;
                end else if (cycle_end) begin
                    settle_d = settle_q - SW'(1);
                    if (settle_q <= SW'(1)) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    state_d    = StIdle;
                    pulse_en_d = 1'b0;
                end else if (cycle_end) begin
                    acq_d = 1'b1;
                    if (avg_q < avg_last_q) begin
                        avg_d = avg_q + CNT_W'(1);
                    end else if (point_q < pts_last_q) begin
                        avg_d    = '0;
                        point_d  = point_q + CNT_W'(1);
                        delay_d  = delay_q + step_q;
                        settle_d = SettleLoad;
                        state_d  = StPostLoad;
                    end else begin
                        pulse_en_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_pll) begin
        if (!reset) begin
            state_q    <= StIdle;
            delay_q    <= '0;
            step_q     <= '0;
            pts_last_q <= '0;
            avg_last_q <= '0;
            point_q    <= '0;
            avg_q      <= '0;
            settle_q   <= '0;
            pulse_en_q <= 1'b0;
            done_q     <= 1'b0;
            acq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            step_q     <= step_d;
            pts_last_q <= pts_last_d;
            avg_last_q <= avg_last_d;
            point_q    <= point_d;
            avg_q      <= avg_d;
            settle_q   <= settle_d;
            pulse_en_q <= pulse_en_d;
            done_q     <= done_d;
            acq_q      <= acq_d;
        end
    end

    assign delay_out = delay_q;
    assign pulse_en  = pulse_en_q;
    assign busy      = (state_q == StArm) || (state_q == StSettle) || (state_q == StRun);
    assign done      = done_q;
    assign acq_valid = acq_q;
    assign point_idx = point_q;
    assign avg_idx   = avg_q;

endmodule

// File: tb/tb_pulse_scan_sequencer.sv
// Bench for pulse_scan_sequencer: two instances (2 and 0 settle periods) checked every clock
// against a period-counting reference model, plus literal checks from hand-worked scans.
module tb_pulse_scan_sequencer;

    logic        clk_pll = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cycle_end = 1'b0;
    logic [31:0] delay_base = '0;
    logic [31:0] delay_step = '0;
    logic [15:0] n_points = '0;
    logic [15:0] n_avg = '0;

    logic [31:0] d_delay [2];
    logic        d_pen   [2];
    logic        d_busy  [2];
    logic        d_done  [2];
    logic        d_acq   [2];
    logic [15:0] d_pt    [2];
    logic [15:0] d_avg   [2];

    int vectors = 0;
    int errors = 0;
    int acq_cnt = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    always #5 clk_pll = ~clk_pll;

    pulse_scan_sequencer #(.WIDTH(32), .CNT_W(16), .SETTLE_CYCLES(2)) u_s2 (
        .clk_pll(clk_pll), .reset(reset), .start(start), .abort(abort),
        .cycle_end(cycle_end), .delay_base(delay_base), .delay_step(delay_step),
        .n_points(n_points), .n_avg(n_avg), .delay_out(d_delay[0]), .pulse_en(d_pen[0]),
        .busy(d_busy[0]), .done(d_done[0]), .acq_valid(d_acq[0]), .point_idx(d_pt[0]),
        .avg_idx(d_avg[0])
    );

    pulse_scan_sequencer #(.WIDTH(32), .CNT_W(16), .SETTLE_CYCLES(0)) u_s0 (
        .clk_pll(clk_pll), .reset(reset), .start(start), .abort(abort),
        .cycle_end(cycle_end), .delay_base(delay_base), .delay_step(delay_step),
        .n_points(n_points), .n_avg(n_avg), .delay_out(d_delay[1]), .pulse_en(d_pen[1]),
        .busy(d_busy[1]), .done(d_done[1]), .acq_valid(d_acq[1]), .point_idx(d_pt[1]),
        .avg_idx(d_avg[1])
    );

    // Model: phase 0 idle, 1 waiting for first wrap, 2 scanning, 3 completion clock.
    // While scanning, m_c counts wraps; each point spans settle + n_avg of them.
    int unsigned m_phase [2];
    logic [31:0] m_base  [2];
    logic [31:0] m_step  [2];
    logic [31:0] m_delay [2];
    int unsigned m_np    [2];
    int unsigned m_na    [2];
    int unsigned m_pt    [2];
    int unsigned m_avg   [2];
    longint      m_c     [2];
    bit          m_pen   [2];
    bit          m_acq   [2];
    bit          m_done  [2];

    task automatic model_step(input int k);
        longint      settle;
        longint      len;
        longint      r;
        logic [31:0] p;
        settle = (k == 0) ? 2 : 0;
        m_acq[k]  = 1'b0;
        m_done[k] = 1'b0;
        if (!reset) begin
            m_phase[k] = 0; m_delay[k] = '0; m_pt[k] = 0; m_avg[k] = 0; m_pen[k] = 1'b0;
            return;
        end
        case (m_phase[k])
            0: if (start) begin
                m_base[k] = delay_base; m_step[k] = delay_step;
                m_np[k] = n_points; m_na[k] = n_avg;
                m_delay[k] = delay_base; m_pt[k] = 0; m_avg[k] = 0;
                if (n_points == 0 || n_avg == 0) m_done[k] = 1'b1;
                else m_phase[k] = 1;
            end
            1: if (abort) begin
                m_phase[k] = 0; m_pen[k] = 1'b0;
            end else if (cycle_end) begin
                m_pen[k] = 1'b1; m_phase[k] = 2; m_c[k] = 0;
            end
            2: if (abort) begin
                m_phase[k] = 0; m_pen[k] = 1'b0;
            end else if (cycle_end) begin
                len = settle + longint'(m_na[k]);
                if ((m_c[k] % len) >= settle) m_acq[k] = 1'b1;
                m_c[k]++;
                if (m_c[k] == longint'(m_np[k]) * len) begin
                    m_pen[k] = 1'b0; m_done[k] = 1'b1; m_phase[k] = 3;
                end else begin
                    p = 32'(m_c[k] / len);
                    r = m_c[k] % len;
                    m_pt[k]    = p;
                    m_avg[k]   = (r >= settle) ? int'(r - settle) : 0;
                    m_delay[k] = m_base[k] + m_step[k] * p;
                end
            end
            default: m_phase[k] = 0;
        endcase
    endtask

    task automatic compare(input int k);
        bit exp_busy;
        exp_busy = (m_phase[k] == 1) || (m_phase[k] == 2);
        vectors++;
        if (d_delay[k] !== m_delay[k] || d_pen[k] !== m_pen[k] || d_busy[k] !== exp_busy ||
            d_done[k] !== m_done[k] || d_acq[k] !== m_acq[k] || d_pt[k] !== m_pt[k][15:0] ||
            d_avg[k] !== m_avg[k][15:0]) begin
            errors++;
            $display("FAIL cycle s%0d t=%0t: got delay=%h pen=%b busy=%b done=%b acq=%b pt=%0d avg=%0d, want delay=%h pen=%b busy=%b done=%b acq=%b pt=%0d avg=%0d",
                     (k == 0) ? 2 : 0, $time, d_delay[k], d_pen[k], d_busy[k], d_done[k],
                     d_acq[k], d_pt[k], d_avg[k], m_delay[k], m_pen[k], exp_busy, m_done[k],
                     m_acq[k], m_pt[k], m_avg[k]);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pll);
        model_step(0);
        model_step(1);
        @(negedge clk_pll);
        compare(0);
        compare(1);
        acq_cnt  += int'(d_acq[0]);
        done_cnt += int'(d_done[0]);
        busy_cnt += int'(d_busy[0]);
    endtask

    // One pulse-generator period: len-1 quiet clocks, then the wrap strobe.
    task automatic period(input int len, input bit ab, input bit rs);
        cycle_end = 1'b0;
        repeat (len - 1) tick();
        cycle_end = 1'b1; abort = ab; reset = ~rs;
        tick();
        cycle_end = 1'b0; abort = 1'b0; reset = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_idle(input int len);
        for (int i = 0; i < 200 && (m_phase[0] != 0 || m_phase[1] != 0); i++) period(len, 0, 0);
        tick();
        tick();
    endtask

    task automatic clear_counts();
        acq_cnt = 0; done_cnt = 0; busy_cnt = 0;
    endtask

    initial begin
        tick();
        tick();
        check("reset_delay", d_delay[0], 32'h0);
        check("reset_busy", {31'b0, d_busy[0]}, 32'h0);
        reset = 1'b1;
        tick();

        // Basic scan.
        delay_base = 32'd1000; delay_step = 32'd200; n_points = 16'd3; n_avg = 16'd4;
        clear_counts();
        pulse_start();
        check("basic_arm_delay", d_delay[0], 32'd1000);
        run_to_idle(50);
        check("basic_acq_count", acq_cnt, 32'd12);
        check("basic_done_count", done_cnt, 32'd1);
        check("basic_final_delay", d_delay[0], 32'd1400);
        check("basic_final_pt", {16'b0, d_pt[0]}, 32'd2);

        // Zero count.
        n_avg = 16'd0;
        clear_counts();
        pulse_start();
        check("zero_done", {31'b0, d_done[0]}, 32'd1);
        check("zero_busy", {31'b0, d_busy[0]}, 32'd0);
        tick();
        check("zero_done_drop", {31'b0, d_done[0]}, 32'd0);
        check("zero_pen", {31'b0, d_pen[0]}, 32'd0);

        // Abort on the third valid wrap of point 1: arm wrap, 10 wraps, then abort wrap.
        n_avg = 16'd4;
        clear_counts();
        pulse_start();
        repeat (11) period(50, 0, 0);
        period(50, 1, 0);
        check("abort_acq", {31'b0, d_acq[0]}, 32'd0);
        check("abort_busy", {31'b0, d_busy[0]}, 32'd0);
        check("abort_pen", {31'b0, d_pen[0]}, 32'd0);
        check("abort_delay", d_delay[0], 32'd1200);
        check("abort_done", done_cnt, 32'd0);
        repeat (3) tick();

        // Same point hit by reset instead.
        pulse_start();
        repeat (11) period(50, 0, 0);
        period(50, 0, 1);
        check("rst_delay", d_delay[0], 32'd0);
        check("rst_pt", {16'b0, d_pt[0]}, 32'd0);
        check("rst_pen", {31'b0, d_pen[0]}, 32'd0);
        repeat (3) tick();

        // Wrap-around and the no-settle instance.
        delay_base = 32'hFFFFFF00; delay_step = 32'h200; n_points = 16'd2; n_avg = 16'd1;
        pulse_start();
        period(20, 0, 0);
        period(20, 0, 0);
        check("nosettle_acq", {31'b0, d_acq[1]}, 32'd1);
        check("nosettle_delay", d_delay[1], 32'h100);
        check("settle_no_acq", {31'b0, d_acq[0]}, 32'd0);
        period(20, 0, 0);
        check("nosettle_done", {31'b0, d_done[1]}, 32'd1);
        run_to_idle(20);
        check("wrap_delay", d_delay[0], 32'h100);

        // Ignored inputs while busy.
        delay_base = 32'd500; delay_step = 32'd100; n_points = 16'd3; n_avg = 16'd2;
        pulse_start();
        repeat (3) period(10, 0, 0);
        delay_step = 32'd999; delay_base = 32'd7; n_points = 16'd9;
        pulse_start();
        run_to_idle(10);
        check("shadow_delay", d_delay[0], 32'd700);

        // Randomized scans with stray starts, parameter changes and aborts.
        for (int it = 0; it < 40; it++) begin
            delay_base = $urandom; delay_step = $urandom;
            n_points = 16'($urandom_range(0, 4)); n_avg = 16'($urandom_range(0, 3));
            pulse_start();
            for (int j = 0; j < 40 && (m_phase[0] != 0 || m_phase[1] != 0); j++) begin
                start = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 5) == 0) delay_step = $urandom;
                period(int'($urandom_range(1, 6)), ($urandom_range(0, 30) == 0), 1'b0);
                start = 1'b0;
            end
            run_to_idle(3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
